// File: rtl/pulse_shaping_interp_fir.sv
// Polyphase interpolating FIR for complex (I/Q) pulse shaping: one input sample
// produces sps_cur output samples, each computed by a serial I/Q MAC over one branch.
module pulse_shaping_interp_fir #(
  parameter int DATA_W         = 16,
  parameter int COEFF_W        = 16,
  parameter int TAPS_PER_PHASE = 8,
  parameter int MAX_SPS        = 8,
  parameter int DEFAULT_SPS    = 4,
  localparam int ADDR_W        = $clog2(MAX_SPS * TAPS_PER_PHASE),
  localparam int SPS_W         = $clog2(MAX_SPS + 1)
) (
  input  logic                  ce_clk,
  input  logic                  ce_rst,
  input  logic [2*DATA_W-1:0]   s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [2*DATA_W-1:0]   m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  input  logic                  coef_wr_en,
  input  logic [ADDR_W-1:0]     coef_wr_addr,
  input  logic [COEFF_W-1:0]    coef_wr_data,
  input  logic                  sps_wr_en,
  input  logic [SPS_W-1:0]      sps_wr_data,
  output logic [SPS_W-1:0]      sps_cur,
  output logic                  busy
);

  localparam int K_W    = $clog2(TAPS_PER_PHASE);
  localparam int PH_W   = ADDR_W - K_W;
  localparam int CNT_W  = K_W + 1;
  localparam int PROD_W = DATA_W + COEFF_W;
  localparam int ACC_W  = DATA_W + COEFF_W + K_W;
  localparam int NCOEF  = MAX_SPS * TAPS_PER_PHASE;
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (COEFF_W - 2);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;

  state_t state, state_nx;

  logic signed [DATA_W-1:0]  x_i [TAPS_PER_PHASE];
  logic signed [DATA_W-1:0]  x_q [TAPS_PER_PHASE];
  logic signed [COEFF_W-1:0] coef [NCOEF];
  logic signed [PROD_W-1:0]  prod_i, prod_q;
  logic signed [ACC_W-1:0]   acc_i, acc_q;
  logic [CNT_W-1:0]          cnt;
  logic [PH_W-1:0]           phase;
  logic                      last_in;
  logic [SPS_W-1:0]          sps_pend;
  logic                      pend_valid;

  logic accept, out_hs, mac_done, last_phase, sps_ok, going_idle;

  function automatic logic [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] r;
    r = (a + RND) >>> (COEFF_W - 1);
    if (r > SAT_HI)
      round_sat = {1'b0, {(DATA_W-1){1'b1}}};
    else if (r < SAT_LO)
      round_sat = {1'b1, {(DATA_W-1){1'b0}}};
    else
      round_sat = r[DATA_W-1:0];
  endfunction

  assign accept     = s_axis_tvalid && s_axis_tready && (state == IDLE);
  assign out_hs     = (state == OUT) && m_axis_tvalid && m_axis_tready;
  assign mac_done   = (state == MAC) && (cnt == CNT_W'(TAPS_PER_PHASE + 1));
  assign last_phase = ((SPS_W'(phase) + SPS_W'(1)) == sps_cur);
  assign sps_ok     = sps_wr_en && (sps_wr_data != SPS_W'(0)) && (sps_wr_data <= SPS_W'(MAX_SPS));
  assign going_idle = out_hs && last_phase;
  assign busy       = (state != IDLE);

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = MAC; else state_nx = IDLE;
      MAC:  if (mac_done) state_nx = OUT; else state_nx = MAC;
      OUT:  if (out_hs) state_nx = last_phase ? IDLE : MAC; else state_nx = OUT;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: delay line, coefficient store, serial MAC, output register, config.
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      for (int i = 0; i < TAPS_PER_PHASE; i++) begin
        x_i[i] <= '0;
        x_q[i] <= '0;
      end
      for (int i = 0; i < NCOEF; i++) coef[i] <= '0;
      prod_i        <= '0;
      prod_q        <= '0;
      acc_i         <= '0;
      acc_q         <= '0;
      cnt           <= '0;
      phase         <= '0;
      last_in       <= 1'b0;
      sps_cur       <= SPS_W'(DEFAULT_SPS);
      sps_pend      <= '0;
      pend_valid    <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      s_axis_tready <= 1'b0;
    end else begin
      s_axis_tready <= (state_nx == IDLE);

      if (coef_wr_en && (state == IDLE) && (int'(coef_wr_addr) < NCOEF))
        coef[coef_wr_addr] <= coef_wr_data;

      // A write landing with an accept or while busy waits until the next IDLE entry.
      if (going_idle) begin
        if (sps_ok)          sps_cur <= sps_wr_data;
        else if (pend_valid) sps_cur <= sps_pend;
        pend_valid <= 1'b0;
      end else if (sps_ok && (state == IDLE) && !accept) begin
        sps_cur <= sps_wr_data;
      end else if (sps_ok) begin
        sps_pend   <= sps_wr_data;
        pend_valid <= 1'b1;
      end

      if (accept) begin
        x_i[0] <= s_axis_tdata[2*DATA_W-1:DATA_W];
        x_q[0] <= s_axis_tdata[DATA_W-1:0];
        for (int i = 1; i < TAPS_PER_PHASE; i++) begin
          x_i[i] <= x_i[i-1];
          x_q[i] <= x_q[i-1];
        end
        last_in <= s_axis_tlast;
        phase   <= '0;
        acc_i   <= '0;
        acc_q   <= '0;
        cnt     <= '0;
      end else if (state == MAC) begin
        if (cnt < CNT_W'(TAPS_PER_PHASE)) begin
          prod_i <= x_i[cnt[K_W-1:0]] * coef[{phase, cnt[K_W-1:0]}];
          prod_q <= x_q[cnt[K_W-1:0]] * coef[{phase, cnt[K_W-1:0]}];
        end
        // Accumulation trails the product register by one cycle.
        if ((cnt >= CNT_W'(1)) && (cnt <= CNT_W'(TAPS_PER_PHASE))) begin
          acc_i <= acc_i + ACC_W'(prod_i);
          acc_q <= acc_q + ACC_W'(prod_q);
        end
        if (mac_done) begin
          m_axis_tdata  <= {round_sat(acc_i), round_sat(acc_q)};
          m_axis_tvalid <= 1'b1;
          m_axis_tlast  <= last_in && last_phase;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else if (out_hs) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
        if (!last_phase) begin
          phase <= phase + PH_W'(1);
          acc_i <= '0;
          acc_q <= '0;
          cnt   <= '0;
        end
      end
    end
  end

endmodule

// File: doc/pulse_shaping_interp_fir.md
PULSE_SHAPING_INTERP_FIR -- requirements
Module: pulse_shaping_interp_fir

Interface
REQ-001 Param DATA_W, default 16: signed width of each I and Q component.
REQ-002 Param COEFF_W, default 16: signed coefficient width, Q1.(COEFF_W-1).
REQ-003 Param TAPS_PER_PHASE, default 8: taps per polyphase branch, power of two.
REQ-004 Param MAX_SPS, default 8: maximum interpolation factor (samples per symbol).
REQ-005 Param DEFAULT_SPS, default 4: interpolation factor after reset.
REQ-006 ce_clk  in  1  sole clock; all logic on rising edge.
REQ-007 ce_rst  in  1  reset, asynchronous, active-high.
REQ-008 s_axis_tdata  in  2*DATA_W  input sample, I in [2*DATA_W-1:DATA_W], Q in [DATA_W-1:0].
REQ-009 s_axis_tvalid / s_axis_tlast  in  1 each  input AXI-Stream valid / end of packet.
REQ-010 s_axis_tready  out  1  input ready.
REQ-011 m_axis_tdata  out  2*DATA_W  output sample, same packing.
REQ-012 m_axis_tvalid / m_axis_tlast  out  1 each  output valid / end of packet.
REQ-013 m_axis_tready  in  1  output ready.
REQ-014 coef_wr_en / coef_wr_addr / coef_wr_data  in  1 / clog2(MAX_SPS*TAPS_PER_PHASE) / COEFF_W  coefficient write; address = phase*TAPS_PER_PHASE + k.
REQ-015 sps_wr_en / sps_wr_data  in  1 / clog2(MAX_SPS+1)  interpolation factor write.
REQ-016 sps_cur  out  clog2(MAX_SPS+1)  active interpolation factor.
REQ-017 busy  out  1  high whenever FSM is not IDLE.

Function
REQ-018 Delay line SHALL hold TAPS_PER_PHASE input samples x[0] (newest) .. x[T-1]; coefficient store SHALL be MAX_SPS*TAPS_PER_PHASE registers.
REQ-019 FSM states SHALL be IDLE, MAC, OUT.
REQ-020 IDLE: s_axis_tready=1; on s_axis_tvalid&tready shift sample into x[0], latch tlast, phase=0, clear accumulators, go MAC.
REQ-021 MAC: one I and one Q multiply-accumulate per cycle over k=0..T-1, acc += x[k]*c[phase*T+k]; one pipeline register on products; then OUT.
REQ-022 First m_axis_tvalid SHALL assert exactly TAPS_PER_PHASE+2 cycles after the input accept edge; each further phase output follows TAPS_PER_PHASE+2 cycles after the previous output handshake.
REQ-023 OUT: m_axis_tvalid=1, tdata stable until m_axis_tready; on handshake, if phase==sps_cur-1 go IDLE, else phase++, clear acc, go MAC.
REQ-024 s_axis_tready SHALL be 0 in MAC and OUT; exactly sps_cur outputs SHALL be produced per accepted input.
REQ-025 m_axis_tlast SHALL be 1 only on the final phase output of an input that carried tlast.
REQ-026 Accumulator width DATA_W+COEFF_W+clog2(TAPS_PER_PHASE), signed; output = (acc + 2^(COEFF_W-2)) >>> (COEFF_W-1), saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1], per component.
REQ-027 sps_wr_data in 1..MAX_SPS SHALL be accepted; 0 or >MAX_SPS SHALL be ignored.
REQ-028 An accepted sps write while busy SHALL be held pending and applied on next entry to IDLE; a later write overwrites the pending value.
REQ-029 coef_wr_en SHALL update the coefficient only when busy=0; writes while busy SHALL be dropped.
REQ-030 Simultaneous input accept and sps write in IDLE: the accepted input SHALL use the old sps_cur; the new value applies from the next input.

Reset
REQ-031 On ce_rst: FSM=IDLE, delay line and coefficients 0, accumulators 0, sps_cur=DEFAULT_SPS, pending sps cleared, m_axis_tvalid/tlast/tdata=0, busy=0, s_axis_tready=0 while asserted, 1 on first cycle after release.
REQ-032 Reset mid-operation SHALL drop the in-flight output immediately (asynchronous), with no output on release.

Verification
REQ-033 Reset: release ce_rst -> m_axis_tvalid=0, s_axis_tready=1, sps_cur=4, busy=0.
REQ-034 Impulse: T=8, sps=4, c[p*8]=8192*(p+1), others 0; input I=1000,Q=0 -> four outputs I=250,500,750,1000, Q=0, first valid 10 cycles after accept.
REQ-035 Saturation: all coefficients 32767; eight inputs I=32767 then eight I=-32768 -> 8th output block I=32767, 16th block I=-32768, no wrap.
REQ-036 Backpressure/tlast: m_axis_tready low 20 cycles in OUT -> tdata stable, s_axis_tready=0, no loss; input with tlast -> tlast only on 4th output.
REQ-037 Config: sps_wr=2 while busy -> current input yields 4 outputs, next yields 2; sps_wr=0 and 9 ignored; coef write while busy leaves coefficient unchanged.
REQ-038 Reset mid-MAC: assert ce_rst -> m_axis_tvalid=0 same cycle; after release, zero input gives zero output.
